// File: rtl/present_key_sequencer_pkg.sv
// ============================================================================
// present_key_sequencer_pkg
// Shared widths, constants and FSM state encoding for the key sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package present_key_sequencer_pkg;

  localparam int KEY_W            = 80;
  localparam int RK_W             = 64;
  localparam int RC_W             = 5;
  localparam int CNT_W            = 6;
  localparam int PRESENT_NUM_KEYS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_SKIP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/present_key_sequencer_if.sv
// ============================================================================
// present_key_sequencer_if
// Key-load request and round-key handshake bundle between the loader/consumer
// side (master) and the sequencer (slave).
// Revision: 1.0
// ============================================================================
`default_nettype none

interface present_key_sequencer_if;
  import present_key_sequencer_pkg::*;

  logic [KEY_W-1:0] key_in;
  logic             start;
  logic             ff;
  logic             abort;
  logic             busy;
  logic [RK_W-1:0]  rk;
  logic [CNT_W-1:0] rk_idx;
  logic             rk_valid;
  logic             rk_ready;
  logic             done;
  logic [KEY_W-1:0] final_key;

  modport master (
    output key_in, start, ff, abort, rk_ready,
    input  busy, rk, rk_idx, rk_valid, done, final_key
  );

  modport slave (
    input  key_in, start, ff, abort, rk_ready,
    output busy, rk, rk_idx, rk_valid, done, final_key
  );

endinterface

`default_nettype wire

// File: rtl/present_key_sequencer_key_schedule.sv
// ============================================================================
// key_schedule
// One combinational PRESENT-80 key-register update: rotate, S-box, counter XOR.
// Revision: 1.0
// ============================================================================
`default_nettype none

module key_schedule
  import present_key_sequencer_pkg::*;
(
  input  logic [KEY_W-1:0] key_i,
  input  logic [RC_W-1:0]  rc_i,
  output logic [KEY_W-1:0] key_o
);

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  logic [KEY_W-1:0] rotated;

  // Left rotation by 61 is the same as right rotation by 19.
  always_comb begin
    rotated        = {key_i[18:0], key_i[KEY_W-1:19]};
    key_o          = rotated;
    key_o[79:76]   = sbox(rotated[79:76]);
    key_o[19:15]   = rotated[19:15] ^ rc_i;
  end

endmodule

`default_nettype wire

// File: rtl/present_key_sequencer.sv
// ============================================================================
// present_key_sequencer
// Loads an 80-bit master key and emits PRESENT round keys over valid/ready,
// or fast-forwards the schedule to produce the final key register.
// Revision: 1.0
// ============================================================================
`default_nettype none

module present_key_sequencer
  import present_key_sequencer_pkg::*;
#(
  parameter int NUM_KEYS = PRESENT_NUM_KEYS
)
(
  input  logic                    clk,
  input  logic                    rst_n,
  present_key_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_KEYS);

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [KEY_W-1:0] final_q, final_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] key_next;
  logic             fire;
  logic             last;

  key_schedule u_key_schedule (
    .key_i (key_q),
    .rc_i  (cnt_q[RC_W-1:0]),
    .key_o (key_next)
  );

  assign fire = (state_q == ST_EMIT) && bus.rk_ready;
  assign last = (cnt_q == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
      final_q <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      final_q <= final_d;
    end
  end

  // Abort takes priority over a handshake in the same cycle; that key is dropped.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    final_d = final_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          key_d   = bus.key_in;
          cnt_d   = CNT_W'(1);
          state_d = bus.ff ? ST_SKIP : ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (fire) begin
          if (last) begin
            state_d = ST_DONE;
          end else begin
            key_d = key_next;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_SKIP: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (last) begin
          state_d = ST_DONE;
        end else begin
          key_d = key_next;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        final_d = key_q;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.busy      = (state_q == ST_EMIT) || (state_q == ST_SKIP);
  assign bus.rk_valid  = (state_q == ST_EMIT);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.rk        = key_q[KEY_W-1:KEY_W-RK_W];
  assign bus.rk_idx    = cnt_q;
  assign bus.final_key = final_q;

endmodule

`default_nettype wire

// File: tb/tb_present_key_sequencer.sv
// ============================================================================
// tb_present_key_sequencer
// Self-checking bench for present_key_sequencer (NUM_KEYS=32 and NUM_KEYS=2).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_present_key_sequencer;
  import present_key_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  present_key_sequencer_if bus ();
  present_key_sequencer_if bus2 ();

  present_key_sequencer #(.NUM_KEYS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  present_key_sequencer #(.NUM_KEYS(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference key schedule straight from the algorithm description.
  logic [3:0]  sbox_t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                               4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [63:0] exp_rk [1:32];
  logic [79:0] exp_final;

  function automatic logic [79:0] next_key(input logic [79:0] k, input int rc);
    logic [79:0] r;
    logic [4:0]  rc5;
    rc5       = rc[4:0];
    r         = {k[18:0], k[79:19]};
    r[79:76]  = sbox_t[r[79:76]];
    r[19:15]  = r[19:15] ^ rc5;
    return r;
  endfunction

  task automatic build_model(input logic [79:0] k, input int n);
    logic [79:0] r;
    r = k;
    for (int i = 1; i <= n; i++) begin
      exp_rk[i] = r[79:16];
      if (i < n) r = next_key(r, i);
    end
    exp_final = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({bus.busy, bus.rk_valid, bus.done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000", {bus.busy, bus.rk_valid, bus.done});
    end
    n_checks++;
    if (bus.rk !== 64'h0 || bus.rk_idx !== 6'd0 || bus.final_key !== 80'h0) begin
      n_fail++;
      $display("FAIL reset_data: got rk=%h idx=%0d final=%h expected zeros", bus.rk, bus.rk_idx, bus.final_key);
    end
    n_checks++;
    if ({bus2.busy, bus2.rk_valid, bus2.done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags_n2: got %b expected 000", {bus2.busy, bus2.rk_valid, bus2.done});
    end
  endtask

  task automatic test_emit(input logic [79:0] key, input bit rand_ready, input bit poke_start,
                           input bit check_consts);
    int          fires;
    int          cyc;
    bit          done_seen;
    bit          pend;
    bit          prev_last_fire;
    bit          rdy;
    logic [63:0] hold_rk;
    logic [5:0]  hold_idx;
    logic [63:0] lit;
    fires = 0; cyc = 0; done_seen = 0; pend = 0; prev_last_fire = 0;
    hold_rk = '0; hold_idx = '0;
    build_model(key, 32);
    bus.key_in = key; bus.ff = 1'b0; bus.start = 1'b1; bus.rk_ready = 1'b0;
    step();
    bus.start = 1'b0;
    n_checks++;
    if (bus.rk_valid !== 1'b1 || bus.rk_idx !== 6'd1) begin
      n_fail++;
      $display("FAIL emit_first: got valid=%b idx=%0d expected valid=1 idx=1", bus.rk_valid, bus.rk_idx);
    end
    while (!done_seen && cyc < 400) begin
      cyc++;
      if (bus.done === 1'b1) begin
        done_seen = 1;
        bus.start = 1'b0;
        n_checks++;
        if (fires != 32 || !prev_last_fire) begin
          n_fail++;
          $display("FAIL emit_done_timing: got fires=%0d last_fire_prev=%0b expected 32/1", fires, prev_last_fire);
        end
      end else if (bus.rk_valid === 1'b1) begin
        if (pend) begin
          n_checks++;
          if (bus.rk !== hold_rk || bus.rk_idx !== hold_idx) begin
            n_fail++;
            $display("FAIL emit_hold: got rk=%h idx=%0d expected rk=%h idx=%0d", bus.rk, bus.rk_idx, hold_rk, hold_idx);
          end
        end
        n_checks++;
        if (fires >= 32 || bus.rk !== exp_rk[fires+1] || bus.rk_idx !== 6'(fires + 1) || bus.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL emit_key: got rk=%h idx=%0d busy=%b expected idx=%0d busy=1", bus.rk, bus.rk_idx, bus.busy, fires + 1);
        end
        if (check_consts && (fires + 1 == 1 || fires + 1 == 2 || fires + 1 == 32)) begin
          lit = (fires + 1 == 1) ? 64'h0000000000000000 :
                (fires + 1 == 2) ? 64'hC000000000000000 : 64'h6DAB31744F41D700;
          n_checks++;
          if (bus.rk !== lit) begin
            n_fail++;
            $display("FAIL emit_known_rk%0d: got %h expected %h", fires + 1, bus.rk, lit);
          end
        end
        rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.rk_ready = rdy;
        if (poke_start) begin
          bus.start  = 1'($urandom_range(0, 1));
          bus.key_in = {$urandom, $urandom, 16'($urandom)};
        end
        pend     = !rdy;
        hold_rk  = bus.rk;
        hold_idx = bus.rk_idx;
        if (rdy) fires++;
        prev_last_fire = rdy && (fires == 32);
      end else begin
        n_checks++;
        n_fail++;
        $display("FAIL emit_valid_drop: got valid=0 expected 1 after %0d fires", fires);
        cyc = 400;
      end
      if (!done_seen) step();
    end
    bus.start = 1'b0;
    bus.rk_ready = 1'b0;
    if (!done_seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL emit_timeout: got no done expected done after 32 fires");
    end
    step();
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.final_key !== exp_final) begin
      n_fail++;
      $display("FAIL emit_after_done: got done=%b busy=%b final=%h expected 0/0/%h", bus.done, bus.busy, bus.final_key, exp_final);
    end
  endtask

  task automatic test_fast_forward(input logic [79:0] key, input bit check_consts);
    int lat;
    build_model(key, 32);
    bus.key_in = key; bus.ff = 1'b1; bus.start = 1'b1; bus.rk_ready = 1'b1;
    step();
    bus.start = 1'b0; bus.ff = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 60) begin
      n_checks++;
      if (bus.rk_valid !== 1'b0 || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL ff_valid: got valid=%b busy=%b expected 0/1 at cycle %0d", bus.rk_valid, bus.busy, lat);
      end
      step();
      lat++;
    end
    n_checks++;
    if (bus.done !== 1'b1 || lat != 33) begin
      n_fail++;
      $display("FAIL ff_latency: got done=%b after %0d cycles expected done after 33", bus.done, lat);
    end
    step();
    n_checks++;
    if (bus.final_key !== exp_final || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL ff_final: got %h done=%b expected %h done=0", bus.final_key, bus.done, exp_final);
    end
    if (check_consts) begin
      n_checks++;
      if (bus.final_key[79:16] !== 64'h6DAB31744F41D700) begin
        n_fail++;
        $display("FAIL ff_final_known: got %h expected 6dab31744f41d700", bus.final_key[79:16]);
      end
    end
    repeat (3) step();
    n_checks++;
    if (bus.final_key !== exp_final) begin
      n_fail++;
      $display("FAIL ff_final_hold: got %h expected %h", bus.final_key, exp_final);
    end
  endtask

  task automatic test_abort();
    logic [79:0] saved_final;
    int          guard;
    bit          saw_done;
    saved_final = bus.final_key;
    bus.key_in = {$urandom, $urandom, 16'($urandom)};
    bus.ff = 1'b0; bus.start = 1'b1; bus.rk_ready = 1'b1;
    step();
    bus.start = 1'b0;
    guard = 0;
    while (bus.rk_idx !== 6'd10 && guard < 20) begin
      step();
      guard++;
    end
    n_checks++;
    if (bus.rk_idx !== 6'd10 || bus.rk_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_reach_idx: got idx=%0d valid=%b expected 10/1", bus.rk_idx, bus.rk_valid);
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.rk_ready = 1'b0;
    n_checks++;
    if (bus.rk_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.final_key !== saved_final) begin
      n_fail++;
      $display("FAIL abort_state: got valid=%b busy=%b done=%b final=%h expected 0/0/0/%h",
               bus.rk_valid, bus.busy, bus.done, bus.final_key, saved_final);
    end
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL abort_no_done: got done/busy activity expected none");
    end
    bus.abort = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n_checks++;
    if (bus.rk_valid !== 1'b1 || bus.rk_idx !== 6'd1) begin
      n_fail++;
      $display("FAIL abort_start_wins: got valid=%b idx=%0d expected 1/1", bus.rk_valid, bus.rk_idx);
    end
    step();
    bus.abort = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.final_key !== saved_final) begin
      n_fail++;
      $display("FAIL abort_second: got busy=%b final=%h expected 0/%h", bus.busy, bus.final_key, saved_final);
    end
  endtask

  task automatic test_reset_mid_skip();
    bus.key_in = {$urandom, $urandom, 16'($urandom)};
    bus.ff = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0; bus.ff = 1'b0;
    repeat (10) step();
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL skip_busy: got busy=%b expected 1", bus.busy);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++;
    if ({bus.busy, bus.rk_valid, bus.done} !== 3'b000 || bus.rk !== 64'h0 ||
        bus.rk_idx !== 6'd0 || bus.final_key !== 80'h0) begin
      n_fail++;
      $display("FAIL reset_mid_skip: got busy=%b valid=%b done=%b rk=%h idx=%0d final=%h expected all zero",
               bus.busy, bus.rk_valid, bus.done, bus.rk, bus.rk_idx, bus.final_key);
    end
    step();
    test_emit(80'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_num_keys_two();
    logic [79:0] key;
    int          fires;
    int          cyc;
    bit          done_seen;
    key = {$urandom, $urandom, 16'($urandom)};
    build_model(key, 2);
    fires = 0; cyc = 0; done_seen = 0;
    bus2.key_in = key; bus2.ff = 1'b0; bus2.start = 1'b1; bus2.rk_ready = 1'b0;
    step();
    bus2.start = 1'b0;
    while (!done_seen && cyc < 50) begin
      cyc++;
      if (bus2.done === 1'b1) begin
        done_seen = 1;
      end else if (bus2.rk_valid === 1'b1) begin
        n_checks++;
        if (fires >= 2 || bus2.rk !== exp_rk[fires+1] || bus2.rk_idx !== 6'(fires + 1)) begin
          n_fail++;
          $display("FAIL n2_key: got rk=%h idx=%0d expected idx=%0d", bus2.rk, bus2.rk_idx, fires + 1);
        end
        bus2.rk_ready = 1'($urandom_range(0, 1));
        if (bus2.rk_ready) fires++;
      end
      if (!done_seen) step();
    end
    bus2.rk_ready = 1'b0;
    n_checks++;
    if (!done_seen || fires != 2) begin
      n_fail++;
      $display("FAIL n2_done: got done_seen=%0b fires=%0d expected 1/2", done_seen, fires);
    end
    step();
    n_checks++;
    if (bus2.final_key !== exp_final || bus2.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL n2_final: got %h busy=%b expected %h busy=0", bus2.final_key, bus2.busy, exp_final);
    end
  endtask

  initial begin
    bus.key_in = '0; bus.start = 1'b0; bus.ff = 1'b0; bus.abort = 1'b0; bus.rk_ready = 1'b0;
    bus2.key_in = '0; bus2.start = 1'b0; bus2.ff = 1'b0; bus2.abort = 1'b0; bus2.rk_ready = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_emit(80'h0, 1'b0, 1'b0, 1'b1);
    test_emit(80'h0, 1'b1, 1'b1, 1'b1);
    test_emit({$urandom, $urandom, 16'($urandom)}, 1'b1, 1'b1, 1'b0);
    test_fast_forward(80'h0, 1'b1);
    test_fast_forward({$urandom, $urandom, 16'($urandom)}, 1'b0);
    test_abort();
    test_reset_mid_skip();
    test_num_keys_two();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
